ps2_host_tx: RTL

Host-to-device PS/2 transmitter: serialises one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the host logic onto the shared PS/2 clock/data lines using the request-to-send / device-clocked protocol, then checks the device's acknowledge bit. Sits beside the keyboard receive path on the same two open-collector lines. The top level turns `ps2c_oe`/`ps2d_oe` into pull-low tristate drivers, and receive logic is suppressed while `tx_idle` is low.

---
 rtl/ps2_host_tx.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (RTS, device-clocked frame, ack check); optional watchdog via PS2_TX_TIMEOUT_EN
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       wr_ps2,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err
);
  typedef enum logic [2:0] {IDLE, RTS, START, DATA, STOP, WAIT_IDLE} state_t;
  localparam int CW = $clog2(INHIBIT_CYCLES > 16 ? INHIBIT_CYCLES : 16);
  state_t state, state_n;
  logic [8:0] sh, sh_n;
  logic [CW-1:0] cnt, cnt_n;
  logic err_n, c_oe_n, d_oe_n;
  logic [1:0] c_sync, d_sync;
  logic [FILTER_LEN-1:0] c_flt, d_flt;
  logic c_lvl, d_lvl, c_prev, fall, tout;
  // synchronise both lines, then only accept a level once the whole filter window agrees
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      c_sync <= '1;
      d_sync <= '1;
      c_flt  <= '1;
      d_flt  <= '1;
      c_lvl  <= 1'b1;
      d_lvl  <= 1'b1;
      c_prev <= 1'b1;
    end else begin
      c_sync <= {c_sync[0], ps2c_in};
      d_sync <= {d_sync[0], ps2d_in};
      c_flt  <= {c_flt[FILTER_LEN-2:0], c_sync[1]};
      d_flt  <= {d_flt[FILTER_LEN-2:0], d_sync[1]};
      c_lvl  <= &c_flt ? 1'b1 : ~|c_flt ? 1'b0 : c_lvl;
      d_lvl  <= &d_flt ? 1'b1 : ~|d_flt ? 1'b0 : d_lvl;
      c_prev <= c_lvl;
    end
  assign fall = c_prev & ~c_lvl;
`ifdef PS2_TX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 2);
  logic [WW-1:0] wd;
  logic busy;
  assign busy = state == START || state == DATA || state == STOP;
  assign tout = busy && wd > WW'(TIMEOUT_CYCLES);
  // watchdog restarts on every device clock fall and when the clock is first released
  always_ff @(posedge clk or negedge reset)
    if (!reset) wd <= '0;
    else wd <= (fall || (state != START && state_n == START) || !busy) ? '0 : tout ? wd : wd + WW'(1);
`else
  assign tout = 1'b0;
`endif
  // registered state, datapath and outputs; outputs follow the next state so they line up with it
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state        <= IDLE;
      sh           <= '0;
      cnt          <= '0;
      tx_err       <= 1'b0;
      ps2c_oe      <= 1'b0;
      ps2d_oe      <= 1'b0;
      tx_idle      <= 1'b1;
      tx_done_tick <= 1'b0;
    end else begin
      state        <= state_n;
      sh           <= sh_n;
      cnt          <= cnt_n;
      tx_err       <= err_n;
      ps2c_oe      <= c_oe_n;
      ps2d_oe      <= d_oe_n;
      tx_idle      <= state_n == IDLE;
      tx_done_tick <= state != IDLE && state_n == IDLE;
    end
  // next state and datapath: frame bits advance only on filtered device clock falls
  always_comb begin
    state_n = state;
    sh_n    = sh;
    cnt_n   = cnt;
    err_n   = tx_err;
    case (state)
      IDLE: if (wr_ps2) begin
        state_n = RTS;
        sh_n    = {~^din, din};
        cnt_n   = CW'(INHIBIT_CYCLES - 1);
        err_n   = 1'b0;
      end
      RTS: if (cnt == '0) state_n = START; else cnt_n = cnt - CW'(1);
      START: if (fall) begin
        state_n = DATA;
        cnt_n   = CW'(8);
      end
      DATA: if (fall) begin
        sh_n = sh >> 1;
        if (cnt == '0) state_n = STOP; else cnt_n = cnt - CW'(1);
      end
      STOP: if (fall) begin
        err_n   = d_lvl;
        state_n = WAIT_IDLE;
      end
      WAIT_IDLE: if (c_lvl && d_lvl) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (tout) begin
      state_n = IDLE;
      err_n   = 1'b1;
    end
  end
  // line drive: clock held only during RTS, data pulled low for start bit and zero bits
  always_comb begin
    c_oe_n = state_n == RTS;
    d_oe_n = state_n == RTS || state_n == START || (state_n == DATA && !sh_n[0]);
  end
endmodule
